// File: rtl/bin_to_bcd_seq.sv
// Purpose : sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock,
//           with overflow detection and optional leading-zero blanking.
// Latency : accept edge k -> o_valid pulse in the cycle after edge k+BIN_WIDTH+1; one job per BIN_WIDTH+2 cycles.
// Backpressure: o_ready is low from accept until the result is delivered; requests seen while busy are dropped.
//
// Ports:
//   i_clk      - system clock, all state changes on the rising edge
//   i_reset    - asynchronous active-high reset; aborts any conversion in flight
//   i_valid    - request to convert i_bin (taken when o_ready is high)
//   i_bin      - unsigned binary input, sampled only on the accept edge
//   o_ready    - high while idle
//   o_valid    - one-cycle pulse when o_bcd/o_overflow have just been updated
//   o_bcd      - result, digit n (10^n) at [4n+3:4n]; all 4'hF on overflow; held between updates
//   o_overflow - last result did not fit in DIGITS digits; held with o_bcd
module bin_to_bcd_seq #(
    parameter int BIN_WIDTH = 8,
    parameter int DIGITS    = 3,
    parameter bit BLANK_LZ  = 1'b0
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_valid,
    input  logic [BIN_WIDTH-1:0]  i_bin,
    output logic                  o_ready,
    output logic                  o_valid,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic                  o_overflow
);

    localparam int SW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 r_state;
    logic [BIN_WIDTH-1:0]   r_shift;
    logic [SW-1:0]          r_scratch;
    logic                   r_ovf;
    logic [CW-1:0]          r_cnt;

    logic [SW-1:0]          w_adj;
    logic [SW-1:0]          w_result;
    logic                   w_lead;

    assign o_ready = (r_state == IDLE);

    // Add-3 correction: any digit >= 5 will be >= 10 after the coming doubling,
    // so pre-bias it so the doubling carries cleanly into the next digit.
    always_comb begin
        w_adj = r_scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_scratch[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    // Final display value: all-blank on overflow, otherwise optional leading-zero
    // blanking from the top digit down. Digit 0 is never blanked so zero still shows "0".
    always_comb begin
        w_result = r_scratch;
        w_lead   = 1'b1;
        if (r_ovf) begin
            w_result = '1;
        end else if (BLANK_LZ) begin
            for (int i = DIGITS - 1; i > 0; i--) begin
                if (w_lead && (r_scratch[4*i +: 4] == 4'd0)) begin
                    w_result[4*i +: 4] = 4'hF;
                end else begin
                    w_lead = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_scratch  <= '0;
            r_ovf      <= 1'b0;
            r_cnt      <= '0;
            o_valid    <= 1'b0;
            o_bcd      <= '0;
            o_overflow <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_valid) begin
                        r_shift   <= i_bin;
                        r_scratch <= '0;
                        r_ovf     <= 1'b0;
                        r_cnt     <= CW'(BIN_WIDTH);
                        r_state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // {scratch, shift} moves left one place; binary MSB enters the BCD LSB.
                    r_scratch <= {w_adj[SW-2:0], r_shift[BIN_WIDTH-1]};
                    r_shift   <= r_shift << 1;
                    // A bit leaving the top digit means the value needs more than DIGITS digits.
                    if (w_adj[SW-1]) begin
                        r_ovf <= 1'b1;
                    end
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    o_bcd      <= w_result;
                    o_overflow <= r_ovf;
                    o_valid    <= 1'b1;
                    r_state    <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        rst;
    logic        v8;
    logic [7:0]  bin8;
    logic        v16;
    logic [15:0] bin16;

    logic        a_rdy, a_vld, a_ovf;
    logic [11:0] a_bcd;
    logic        b_rdy, b_vld, b_ovf;
    logic [11:0] b_bcd;
    logic        c_rdy, c_vld, c_ovf;
    logic [7:0]  c_bcd;
    logic        d_rdy, d_vld, d_ovf;
    logic [19:0] d_bcd;

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A: defaults, B: defaults with blanking, C: two digits, D: 16-bit / five digits
    bin_to_bcd_seq #(.BIN_WIDTH(8), .DIGITS(3), .BLANK_LZ(1'b0)) u_a (
        .i_clk(clk), .i_reset(rst), .i_valid(v8), .i_bin(bin8),
        .o_ready(a_rdy), .o_valid(a_vld), .o_bcd(a_bcd), .o_overflow(a_ovf));
    bin_to_bcd_seq #(.BIN_WIDTH(8), .DIGITS(3), .BLANK_LZ(1'b1)) u_b (
        .i_clk(clk), .i_reset(rst), .i_valid(v8), .i_bin(bin8),
        .o_ready(b_rdy), .o_valid(b_vld), .o_bcd(b_bcd), .o_overflow(b_ovf));
    bin_to_bcd_seq #(.BIN_WIDTH(8), .DIGITS(2), .BLANK_LZ(1'b0)) u_c (
        .i_clk(clk), .i_reset(rst), .i_valid(v8), .i_bin(bin8),
        .o_ready(c_rdy), .o_valid(c_vld), .o_bcd(c_bcd), .o_overflow(c_ovf));
    bin_to_bcd_seq #(.BIN_WIDTH(16), .DIGITS(5), .BLANK_LZ(1'b0)) u_d (
        .i_clk(clk), .i_reset(rst), .i_valid(v16), .i_bin(bin16),
        .o_ready(d_rdy), .o_valid(d_vld), .o_bcd(d_bcd), .o_overflow(d_ovf));

    // Reference: decimal digits by division, overflow by range, blanking by scanning down.
    // Returns {overflow, 40-bit digit vector}.
    function automatic logic [40:0] model(longint unsigned v, int d, bit blank);
        logic [39:0]       r;
        longint unsigned   lim;
        longint unsigned   t;
        r   = '0;
        lim = 1;
        for (int i = 0; i < d; i++) lim = lim * 10;
        if (v >= lim) begin
            for (int i = 0; i < d; i++) r[4*i +: 4] = 4'hF;
            return {1'b1, r};
        end
        t = v;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        if (blank) begin
            for (int i = d - 1; i > 0; i--) begin
                if (r[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'hF;
                else break;
            end
        end
        return {1'b0, r};
    endfunction

    function automatic bit obs_rdy(bit wide);
        return wide ? d_rdy : a_rdy;
    endfunction

    function automatic bit obs_vld(bit wide);
        return wide ? d_vld : a_vld;
    endfunction

    // One complete request: checks ready, latency, stall length, results and pulse width.
    task automatic conv(input bit wide, input longint unsigned v);
        int          lat;
        int          lowc;
        bit          seen;
        int          bw;
        logic [40:0] e;
        bw = wide ? 16 : 8;
        @(negedge clk);
        if (wide) begin v16 = 1'b1; bin16 = 16'(v); end
        else begin v8 = 1'b1; bin8 = 8'(v); end
        total++;
        if (obs_rdy(wide) !== 1'b1) begin
            bad++;
            $display("FAIL ready_before_accept: got %b want 1 (value %0d)", obs_rdy(wide), v);
        end
        @(posedge clk);
        @(negedge clk);
        // Inputs change right after the accept edge and must be ignored.
        if (wide) begin v16 = 1'b0; bin16 = 16'($urandom); end
        else begin v8 = 1'b0; bin8 = 8'($urandom); end
        lat  = -1;
        lowc = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (obs_rdy(wide) == 1'b0) lowc++;
            if (obs_vld(wide) == 1'b1) begin
                seen = 1'b1;
                lat  = i;
            end else begin
                @(negedge clk);
            end
        end
        total++;
        if (!seen || lat != bw + 1) begin
            bad++;
            $display("FAIL latency: got %0d want %0d (value %0d)", lat, bw + 1, v);
        end
        total++;
        if (lowc != bw + 1) begin
            bad++;
            $display("FAIL ready_low_cycles: got %0d want %0d (value %0d)", lowc, bw + 1, v);
        end
        if (wide) begin
            e = model(v, 5, 1'b0);
            total++;
            if ({d_ovf, d_bcd} !== {e[40], e[19:0]}) begin
                bad++;
                $display("FAIL result_w16: got %b/%h want %b/%h (value %0d)", d_ovf, d_bcd, e[40], e[19:0], v);
            end
        end else begin
            e = model(v, 3, 1'b0);
            total++;
            if ({a_ovf, a_bcd} !== {e[40], e[11:0]}) begin
                bad++;
                $display("FAIL result_a: got %b/%h want %b/%h (value %0d)", a_ovf, a_bcd, e[40], e[11:0], v);
            end
            e = model(v, 3, 1'b1);
            total++;
            if ({b_ovf, b_bcd} !== {e[40], e[11:0]}) begin
                bad++;
                $display("FAIL result_blank: got %b/%h want %b/%h (value %0d)", b_ovf, b_bcd, e[40], e[11:0], v);
            end
            e = model(v, 2, 1'b0);
            total++;
            if ({c_ovf, c_bcd} !== {e[40], e[7:0]}) begin
                bad++;
                $display("FAIL result_2dig: got %b/%h want %b/%h (value %0d)", c_ovf, c_bcd, e[40], e[7:0], v);
            end
        end
        @(negedge clk);
        total++;
        if (obs_vld(wide) !== 1'b0) begin
            bad++;
            $display("FAIL valid_pulse_width: got %b want 0 (value %0d)", obs_vld(wide), v);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; v8 = 1'b0; bin8 = '0; v16 = 1'b0; bin16 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({a_rdy, a_vld, a_ovf, a_bcd} !== {1'b1, 1'b0, 1'b0, 12'h000}) begin
            bad++;
            $display("FAIL reset_a: got %b%b%b/%h want 100/000", a_rdy, a_vld, a_ovf, a_bcd);
        end
        total++;
        if ({d_rdy, d_vld, d_ovf, d_bcd} !== {1'b1, 1'b0, 1'b0, 20'h00000}) begin
            bad++;
            $display("FAIL reset_d: got %b%b%b/%h want 100/00000", d_rdy, d_vld, d_ovf, d_bcd);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({a_rdy, c_rdy, b_rdy} !== 3'b111) begin
            bad++;
            $display("FAIL ready_after_release: got %b want 111", {a_rdy, c_rdy, b_rdy});
        end
    endtask

    task automatic test_basic();
        conv(1'b0, 255);
        total++;
        if ({a_ovf, a_bcd} !== {1'b0, 12'h255}) begin
            bad++;
            $display("FAIL basic_255: got %b/%h want 0/255", a_ovf, a_bcd);
        end
    endtask

    task automatic test_blanking();
        conv(1'b0, 0);
        total++;
        if ({b_bcd, a_bcd} !== {12'hFF0, 12'h000}) begin
            bad++;
            $display("FAIL blank_zero: got %h/%h want ff0/000", b_bcd, a_bcd);
        end
        conv(1'b0, 7);
        total++;
        if ({b_bcd, a_bcd} !== {12'hFF7, 12'h007}) begin
            bad++;
            $display("FAIL blank_seven: got %h/%h want ff7/007", b_bcd, a_bcd);
        end
    endtask

    task automatic test_overflow();
        conv(1'b0, 99);
        total++;
        if ({c_ovf, c_bcd} !== {1'b0, 8'h99}) begin
            bad++;
            $display("FAIL ovf_99: got %b/%h want 0/99", c_ovf, c_bcd);
        end
        conv(1'b0, 100);
        total++;
        if ({c_ovf, c_bcd} !== {1'b1, 8'hFF}) begin
            bad++;
            $display("FAIL ovf_100: got %b/%h want 1/ff", c_ovf, c_bcd);
        end
        conv(1'b0, 42);
        total++;
        if ({c_ovf, c_bcd} !== {1'b0, 8'h42}) begin
            bad++;
            $display("FAIL ovf_clear_42: got %b/%h want 0/42", c_ovf, c_bcd);
        end
    endtask

    task automatic test_back_to_back();
        int          vals[3];
        int          idx;
        int          acc[$];
        logic [12:0] res[$];
        bit          pend;
        logic [40:0] e;
        vals = '{10, 20, 30};
        idx  = 0;
        pend = 1'b0;
        @(negedge clk);
        v8 = 1'b1;
        for (int cyc = 0; cyc < 100 && res.size() < 3; cyc++) begin
            if (a_vld) res.push_back({a_ovf, a_bcd});
            if (pend) acc.push_back(cyc);
            pend = 1'b0;
            if (idx < 3 && a_rdy) begin
                bin8 = 8'(vals[idx]);
                idx++;
                pend = 1'b1;
            end else begin
                bin8 = 8'($urandom);
                if (idx >= 3) v8 = 1'b0;
            end
            @(negedge clk);
        end
        v8 = 1'b0;
        total++;
        if (acc.size() != 3 || res.size() != 3) begin
            bad++;
            $display("FAIL b2b_counts: got %0d accepts %0d results want 3/3", acc.size(), res.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                total++;
                if (acc[i] - acc[i-1] != 10) begin
                    bad++;
                    $display("FAIL b2b_spacing: got %0d want 10", acc[i] - acc[i-1]);
                end
            end
            for (int i = 0; i < 3; i++) begin
                e = model(longint'(vals[i]), 3, 1'b0);
                total++;
                if (res[i] !== {e[40], e[11:0]}) begin
                    bad++;
                    $display("FAIL b2b_result: got %h want %h (index %0d)", res[i], {e[40], e[11:0]}, i);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit stray;
        @(negedge clk);
        v8 = 1'b1; bin8 = 8'd200;
        @(posedge clk);
        @(negedge clk);
        v8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if ({a_rdy, a_vld, a_ovf, a_bcd, c_bcd} !== {1'b1, 1'b0, 1'b0, 12'h000, 8'h00}) begin
            bad++;
            $display("FAIL reset_mid_outputs: got %b%b%b/%h/%h want 100/000/00", a_rdy, a_vld, a_ovf, a_bcd, c_bcd);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        stray = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (a_vld || b_vld || c_vld) stray = 1'b1;
        end
        total++;
        if (stray || a_bcd !== 12'h000 || a_rdy !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_abort: got stray=%b bcd=%h rdy=%b want 0/000/1", stray, a_bcd, a_rdy);
        end
        conv(1'b0, 63);
        total++;
        if (a_bcd !== 12'h063) begin
            bad++;
            $display("FAIL after_reset_63: got %h want 063", a_bcd);
        end
    endtask

    task automatic test_wide();
        conv(1'b1, 65535);
        total++;
        if ({d_ovf, d_bcd} !== {1'b0, 20'h65535}) begin
            bad++;
            $display("FAIL wide_65535: got %b/%h want 0/65535", d_ovf, d_bcd);
        end
        for (int i = 0; i < 15; i++) conv(1'b1, longint'($urandom_range(0, 65535)));
    endtask

    task automatic test_random8();
        for (int i = 0; i < 25; i++) begin
            if (i % 3 == 0) conv(1'b0, longint'($urandom_range(0, 15)));
            else conv(1'b0, longint'($urandom_range(0, 255)));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_blanking();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        test_wide();
        test_random8();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double dabble) method. It is the multi-digit successor to the desk clock's combinational 6-bit converter. It handles any input width and digit count, one bit per clock, behind a valid/ready handshake. It adds overflow detection and optional leading-zero blanking. It feeds the display/segment-driver path wherever values wider than 0-63 must be shown, such as counters, years or calibration readouts.

Parameters:
BIN_WIDTH, 8, width of binary input; legal range 1..32.
DIGITS, 3, number of BCD output digits; legal range 1..10.
BLANK_LZ, 0, when 1 replace leading zero digits with 4'hF (blank code); digit 0 is never blanked.

Ports:
i_clk  input  1  system clock; all state changes on rising edge.
i_reset  input  1  asynchronous, active-high reset.
i_valid  input  1  request to convert i_bin.
i_bin  input  BIN_WIDTH  unsigned binary value; sampled only on accept.
o_ready  output  1  block idle and able to accept; equals (state == IDLE).
o_valid  output  1  one-cycle pulse: o_bcd/o_overflow just updated.
o_bcd  output  4*DIGITS  result; digit n (10^n) at [4n+3:4n]; held between updates.
o_overflow  output  1  last result exceeded 10^DIGITS-1; held with o_bcd.

Behaviour:
- Reset (async assert, sync release): state=IDLE, o_valid=0, o_bcd=0, o_overflow=0, internal shift/scratch registers=0. o_ready=1 while in reset and after release.
- States: IDLE, SHIFT, DONE.
- IDLE: accept on a rising edge where i_valid && o_ready.
  - On accept: latch i_bin into shift register, clear BCD scratch (4*DIGITS bits), clear overflow sticky, load bit counter = BIN_WIDTH, go to SHIFT.
  - i_valid with o_ready=0 is ignored; no queuing.
- SHIFT, once per cycle:
  - Every scratch digit >= 5 gets +3 (4-bit add).
  - Then {scratch, shift} shifts left by 1, MSB of binary into scratch LSB.
  - A 1 shifted out of scratch MSB sets the overflow sticky.
  - Counter decrements; after the BIN_WIDTH-th shift go to DONE.
- DONE (single cycle):
  - Register o_bcd and o_overflow and raise o_valid for exactly this one cycle.
  - Go to IDLE; o_ready is 1 on the following cycle.
- Latency: accept edge k; o_valid high in the cycle following edge k+BIN_WIDTH+1; o_ready low for BIN_WIDTH+1 cycles after accept.
- Throughput: one conversion per BIN_WIDTH+2 cycles.
- Overflow: when the sticky is set, o_bcd = all 4'hF (regardless of BLANK_LZ) and o_overflow=1. Otherwise o_overflow=0.
- Blanking (BLANK_LZ=1, no overflow): scanning from digit DIGITS-1 downward, each zero digit until the first nonzero digit becomes 4'hF. Digit 0 always shows its value, so 0 displays as blanks followed by 0.
- o_bcd/o_overflow change only in DONE or reset; stable otherwise.
- Reset mid-conversion aborts immediately. No o_valid is produced; outputs return to reset values.
- i_bin changes after the accept edge have no effect.

Test Plan:
- Defaults, i_bin=8'd255 accepted at edge 0 -> o_ready low 9 cycles; o_valid single pulse after edge 9; o_bcd=12'h255, o_overflow=0.
- Defaults, i_bin=0, then i_bin=8'd7 with BLANK_LZ=1 -> first o_bcd=12'hFF0, second 12'hFF7; with BLANK_LZ=0 -> 12'h000, 12'h007.
- BIN_WIDTH=8, DIGITS=2: i_bin=99 -> o_bcd=8'h99, o_overflow=0; i_bin=100 -> o_bcd=8'hFF, o_overflow=1; next i_bin=42 -> 8'h42, o_overflow cleared.
- i_valid held high continuously with values 10, 20, 30 -> accepts exactly every 10 cycles; results 12'h010, 12'h020, 12'h030 in order; input changes during SHIFT ignored.
- Assert i_reset 4 cycles into a conversion of 200 -> no o_valid; o_bcd=0, o_ready=1 after release; a new request of 63 converts to 12'h063.
- BIN_WIDTH=16, DIGITS=5, i_bin=65535 -> o_bcd=20'h65535 after 17 cycles; random sweep matches the software model.
